// File: rtl/result_drain_unit.sv
// Drains a snapshot of four signed MMU accumulators onto an 8-bit valid/ready bus,
// either as full 16-bit words (high byte first) or as saturated int8 values.
module result_drain_unit #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sat_mode,
  input  logic [4*ACC_W-1:0] res_in,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

  state_t                  state_q;
  logic [3:0][ACC_W-1:0]   buf_q;
  logic                    mode_q;
  logic [2:0]              idx_q;
  logic [2:0]              idx_d;
  logic                    overrun_q;
  logic [2:0]              last_idx;
  logic                    at_last;
  logic [3:0][OUT_W-1:0]   sat_byte;

  assign last_idx = mode_q ? 3'd3 : 3'd7;
  assign at_last  = (idx_q == last_idx);
  assign idx_d    = at_last ? 3'd0 : idx_q + 3'd1;

  // Clamp each captured element to the int8 range once; the mux just picks one.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sat
    logic signed [ACC_W-1:0] elem;
    assign elem = buf_q[gi];
    assign sat_byte[gi] = (elem > SAT_MAX) ? {1'b0, {(OUT_W-1){1'b1}}} :
                          (elem < SAT_MIN) ? {1'b1, {(OUT_W-1){1'b0}}} :
                          elem[OUT_W-1:0];
  end

  always_comb begin
    out_data = '0;
    if (state_q == SEND) begin
      if (mode_q)
        out_data = sat_byte[idx_q[1:0]];
      else if (!idx_q[0])
        out_data = buf_q[idx_q[2:1]][ACC_W-1 -: OUT_W];
      else
        out_data = buf_q[idx_q[2:1]][OUT_W-1:0];
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_last  = (state_q == SEND) && at_last;
  assign done      = (state_q == DONE);
  assign overrun   = overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      mode_q    <= 1'b0;
      idx_q     <= 3'd0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            buf_q   <= res_in;
            mode_q  <= sat_mode;
            idx_q   <= 3'd0;
            state_q <= SEND;
          end
        end
        SEND: begin
          // A second start cannot be honoured until the current snapshot is out.
          overrun_q <= start;
          if (out_ready) begin
            idx_q <= idx_d;
            if (at_last)
              state_q <= DONE;
          end
        end
        DONE: begin
          if (start) begin
            buf_q   <= res_in;
            mode_q  <= sat_mode;
            idx_q   <= 3'd0;
            state_q <= SEND;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain_unit.sv
// Randomised bench for result_drain_unit: expected byte streams come from a
// plain-arithmetic model of the byte ordering and int8 clamping rules.
module tb_result_drain_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sat_mode = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] res_in = '0;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy, done, overrun;

  int vec = 0;
  int err = 0;

  logic [7:0] got_q[$];
  bit         last_q[$];
  logic [7:0] exp_q[$];
  bit         exp_last_q[$];
  int         done_cnt, hold_bad, ovr_cnt, busy_low, n_cyc;
  bit         timed_out, post_valid, post_done;

  always #5 clk = ~clk;

  result_drain_unit #(.ACC_W(16), .OUT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sat_mode (sat_mode),
    .res_in   (res_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  // Reference: element order c00..c11, high byte first, or signed clamp to int8.
  task automatic add_exp(input logic [63:0] r, input bit m);
    for (int e = 0; e < 4; e++) begin
      logic signed [15:0] v;
      int sv;
      v  = r[16*e +: 16];
      sv = v;
      if (!m) begin
        exp_q.push_back(v[15:8]);
        exp_last_q.push_back(1'b0);
        exp_q.push_back(v[7:0]);
      end else if (sv > 127) exp_q.push_back(8'h7F);
      else if (sv < -128)    exp_q.push_back(8'h80);
      else                   exp_q.push_back(8'(sv));
      exp_last_q.push_back(e == 3);
    end
  endtask

  task automatic clear_exp();
    exp_q.delete();
    exp_last_q.delete();
  endtask

  // Called on a negedge; returns on the negedge after the start edge.
  task automatic kick(input logic [63:0] r, input bit m);
    res_in   = r;
    sat_mode = m;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    res_in   = {$urandom, $urandom};
  endtask

  // Consumer: collects accepted bytes, scrambles res_in/sat_mode, optionally
  // fires a start mid-stream (ovr_at) or in the DONE cycle (b2b).
  task automatic drain(input int rdy_mode, input int exp_dones, input int ovr_at,
                       input bit b2b, input logic [63:0] nres, input bit nmode);
    int ph;
    bit holding;
    logic [7:0] held;
    ph = 0; holding = 1'b0; held = '0;
    got_q.delete(); last_q.delete();
    done_cnt = 0; hold_bad = 0; ovr_cnt = 0; busy_low = 0; n_cyc = 0;
    timed_out = 1'b1; post_valid = 1'b0; post_done = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      start    = 1'b0;
      res_in   = {$urandom, $urandom};
      sat_mode = 1'($urandom);
      if (overrun) ovr_cnt++;
      if (!busy) busy_low++;
      if (out_valid) begin
        if (holding && out_data !== held) hold_bad++;
        if (ovr_at >= 0 && got_q.size() == ovr_at) begin
          start  = 1'b1;
          ovr_at = -1;
        end
        case (rdy_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (ph % 3 == 0);
          default: out_ready = 1'($urandom);
        endcase
        ph++;
        if (out_ready) begin
          got_q.push_back(out_data);
          last_q.push_back(out_last);
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          held    = out_data;
        end
      end else begin
        out_ready = 1'($urandom);
      end
      if (done) begin
        done_cnt++;
        if (b2b) begin
          res_in   = nres;
          sat_mode = nmode;
          start    = 1'b1;
          b2b      = 1'b0;
        end else if (done_cnt >= exp_dones) begin
          n_cyc = cyc;
          @(negedge clk);
          start      = 1'b0;
          post_valid = out_valid;
          post_done  = done;
          timed_out  = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    vec++; if (out_data !== 8'h00) begin err++; $display("FAIL rst_data: got %02h expected 00", out_data); end
    vec++; if ({out_last, busy, done, overrun} !== 4'b0) begin err++; $display("FAIL rst_flags: got %b expected 0000", {out_last, busy, done, overrun}); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL idle_valid cyc%0d: got %b expected 0", i, out_valid); end
    end
    $display("test_reset done");
  endtask

  task automatic test_full();
    logic [63:0] r;
    r = {16'h8000, 16'h00FF, 16'hFF80, 16'h0123};
    clear_exp(); add_exp(r, 1'b0);
    kick(r, 1'b0);
    vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL full_latency: got %b expected 1", out_valid); end
    drain(0, 1, -1, 1'b0, '0, 1'b0);
    vec++; if (timed_out) begin err++; $display("FAIL full_timeout: got 1 expected 0"); end
    vec++; if (got_q.size() != exp_q.size()) begin err++; $display("FAIL full_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] g; bit l;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      l = (i < last_q.size()) ? last_q[i] : 1'b0;
      vec++; if (g !== exp_q[i]) begin err++; $display("FAIL full_byte%0d: got %02h expected %02h", i, g, exp_q[i]); end
      vec++; if (l !== exp_last_q[i]) begin err++; $display("FAIL full_last%0d: got %b expected %b", i, l, exp_last_q[i]); end
    end
    vec++; if (n_cyc != 8) begin err++; $display("FAIL full_done_cycle: got %0d expected 8", n_cyc); end
    vec++; if (post_done !== 1'b0 || post_valid !== 1'b0) begin err++; $display("FAIL full_after: got done=%b valid=%b expected 0 0", post_done, post_valid); end
    vec++; if (busy_low != 1) begin err++; $display("FAIL full_busy_low: got %0d expected 1", busy_low); end
    $display("test_full done: %0d bytes", got_q.size());
  endtask

  task automatic test_sat();
    logic [63:0] rs[2];
    rs[0] = {16'h8000, 16'h00FF, 16'hFF80, 16'h0123};
    rs[1] = {16'h0080, 16'hFF7F, 16'hFF81, 16'h007F};
    for (int t = 0; t < 2; t++) begin
      clear_exp(); add_exp(rs[t], 1'b1);
      kick(rs[t], 1'b1);
      drain(0, 1, -1, 1'b0, '0, 1'b0);
      vec++; if (timed_out || got_q.size() != 4) begin err++; $display("FAIL sat%0d_count: got %0d expected 4", t, got_q.size()); end
      for (int i = 0; i < 4; i++) begin
        logic [7:0] g; bit l;
        g = (i < got_q.size()) ? got_q[i] : 8'hxx;
        l = (i < last_q.size()) ? last_q[i] : 1'b0;
        vec++; if (g !== exp_q[i]) begin err++; $display("FAIL sat%0d_byte%0d: got %02h expected %02h", t, i, g, exp_q[i]); end
        vec++; if (l !== exp_last_q[i]) begin err++; $display("FAIL sat%0d_last%0d: got %b expected %b", t, i, l, exp_last_q[i]); end
      end
      vec++; if (n_cyc != 4) begin err++; $display("FAIL sat%0d_done_cycle: got %0d expected 4", t, n_cyc); end
      $display("test_sat pass %0d done: %0d bytes", t, got_q.size());
    end
  endtask

  task automatic test_backpressure();
    for (int t = 0; t < 2; t++) begin
      logic [63:0] r;
      bit m;
      r = {$urandom, $urandom};
      m = (t == 1);
      clear_exp(); add_exp(r, m);
      kick(r, m);
      drain(t + 1, 1, -1, 1'b0, '0, 1'b0);
      vec++; if (timed_out || got_q.size() != exp_q.size()) begin err++; $display("FAIL bp%0d_count: got %0d expected %0d", t, got_q.size(), exp_q.size()); end
      vec++; if (hold_bad != 0) begin err++; $display("FAIL bp%0d_stable: got %0d changes expected 0", t, hold_bad); end
      for (int i = 0; i < exp_q.size(); i++) begin
        logic [7:0] g;
        g = (i < got_q.size()) ? got_q[i] : 8'hxx;
        vec++; if (g !== exp_q[i]) begin err++; $display("FAIL bp%0d_byte%0d: got %02h expected %02h", t, i, g, exp_q[i]); end
      end
      $display("test_backpressure pass %0d done: %0d bytes", t, got_q.size());
    end
  endtask

  task automatic test_overrun();
    logic [63:0] r;
    r = {$urandom, $urandom};
    clear_exp(); add_exp(r, 1'b0);
    kick(r, 1'b0);
    drain(2, 1, 3, 1'b0, '0, 1'b0);
    vec++; if (ovr_cnt != 1) begin err++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt); end
    vec++; if (done_cnt != 1 || timed_out) begin err++; $display("FAIL ovr_done: got %0d expected 1", done_cnt); end
    vec++; if (got_q.size() != exp_q.size()) begin err++; $display("FAIL ovr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] g;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vec++; if (g !== exp_q[i]) begin err++; $display("FAIL ovr_byte%0d: got %02h expected %02h", i, g, exp_q[i]); end
    end
    $display("test_overrun done: %0d overrun pulses", ovr_cnt);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 2; t++) begin
      logic [63:0] r1, r2;
      bit m2;
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      m2 = (t == 1);
      clear_exp(); add_exp(r1, 1'b0); add_exp(r2, m2);
      kick(r1, 1'b0);
      drain(0, 2, -1, 1'b1, r2, m2);
      vec++; if (timed_out || got_q.size() != exp_q.size()) begin err++; $display("FAIL b2b%0d_count: got %0d expected %0d", t, got_q.size(), exp_q.size()); end
      vec++; if (done_cnt != 2) begin err++; $display("FAIL b2b%0d_dones: got %0d expected 2", t, done_cnt); end
      vec++; if (busy_low != 2) begin err++; $display("FAIL b2b%0d_busy_low: got %0d expected 2", t, busy_low); end
      vec++; if (n_cyc != exp_q.size() + 1) begin err++; $display("FAIL b2b%0d_cycles: got %0d expected %0d", t, n_cyc, exp_q.size() + 1); end
      vec++; if (ovr_cnt != 0) begin err++; $display("FAIL b2b%0d_overrun: got %0d expected 0", t, ovr_cnt); end
      for (int i = 0; i < exp_q.size(); i++) begin
        logic [7:0] g; bit l;
        g = (i < got_q.size()) ? got_q[i] : 8'hxx;
        l = (i < last_q.size()) ? last_q[i] : 1'b0;
        vec++; if (g !== exp_q[i]) begin err++; $display("FAIL b2b%0d_byte%0d: got %02h expected %02h", t, i, g, exp_q[i]); end
        vec++; if (l !== exp_last_q[i]) begin err++; $display("FAIL b2b%0d_last%0d: got %b expected %b", t, i, l, exp_last_q[i]); end
      end
      $display("test_back_to_back pass %0d done: %0d bytes", t, got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    kick({$urandom, $urandom}, 1'b0);
    out_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
    #2 rst = 1'b0;
    #1;
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    vec++; if (out_data !== 8'h00) begin err++; $display("FAIL mid_rst_data: got %02h expected 00", out_data); end
    vec++; if ({out_last, busy, done, overrun} !== 4'b0) begin err++; $display("FAIL mid_rst_flags: got %b expected 0000", {out_last, busy, done, overrun}); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL mid_idle_valid cyc%0d: got %b expected 0", i, out_valid); end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [15:0] pool[8];
    pool = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
    for (int t = 0; t < 10; t++) begin
      logic [63:0] r;
      bit m;
      for (int e = 0; e < 4; e++)
        r[16*e +: 16] = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : 16'($urandom);
      m = 1'($urandom);
      clear_exp(); add_exp(r, m);
      kick(r, m);
      drain(2, 1, -1, 1'b0, '0, 1'b0);
      vec++; if (timed_out || got_q.size() != exp_q.size()) begin err++; $display("FAIL rnd%0d_count: got %0d expected %0d", t, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        logic [7:0] g;
        g = (i < got_q.size()) ? got_q[i] : 8'hxx;
        vec++; if (g !== exp_q[i]) begin err++; $display("FAIL rnd%0d_byte%0d: got %02h expected %02h", t, i, g, exp_q[i]); end
      end
      $display("test_random pass %0d mode=%0d res=%016h bytes=%0d", t, m, r, got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_sat();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
